// File: rtl/lcd_update_scheduler.sv
// Sequences every write to the character-LCD core: HD44780 power-up init, then a
// 16-character line-1 label rewrite whenever the filter selection changes.
module lcd_update_scheduler #(
    parameter int POWERUP_CYCLES   = 750000,
    parameter int GAP_CYCLES       = 2000,
    parameter int CLEAR_GAP_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] current_state,
    output logic       wr_valid,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       busy,
    output logic       init_done
);

    localparam int MAX_WAIT = (POWERUP_CYCLES > CLEAR_GAP_CYCLES) ? POWERUP_CYCLES : CLEAR_GAP_CYCLES;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_GAP_CYCLES);

    localparam logic [2:0] PWR_WAIT = 3'd0;
    localparam logic [2:0] INIT     = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] SET_ADDR = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;
    localparam logic [2:0] IDLE     = 3'd5;

    localparam logic [127:0] LABEL_0 = "NO FILTER       ";
    localparam logic [127:0] LABEL_1 = "BLUR            ";
    localparam logic [127:0] LABEL_2 = "EDGE DETECT     ";
    localparam logic [127:0] LABEL_3 = "INVERT          ";

    logic [2:0]    state;
    logic [CW-1:0] gap_cnt;
    logic [1:0]    init_idx;
    logic [3:0]    char_idx;
    logic [1:0]    snap;
    logic [1:0]    shown_state;
    logic          xfer;
    logic [CW-1:0] gap_load;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Character 0 sits in the most significant byte of each string constant.
    function automatic logic [7:0] label_char(input logic [1:0] sel, input logic [3:0] idx);
        logic [127:0] text;
        case (sel)
            2'd0:    text = LABEL_0;
            2'd1:    text = LABEL_1;
            2'd2:    text = LABEL_2;
            default: text = LABEL_3;
        endcase
        return text[{~idx, 3'b000} +: 8];
    endfunction

    assign xfer     = wr_valid & wr_ready;
    assign gap_load = (!wr_rs && wr_data == 8'h01) ? CLR_LOAD : GAP_LOAD;
    assign busy     = (state != IDLE);

    // NOTE: all state updates use non-blocking assignments so every branch sees
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PWR_WAIT;
            gap_cnt     <= '0;
            init_idx    <= 2'd0;
            char_idx    <= 4'd0;
            snap        <= 2'b00;
            shown_state <= 2'b00;
            wr_valid    <= 1'b0;
            wr_rs       <= 1'b0;
            wr_data     <= 8'h00;
            init_done   <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (gap_cnt == PWR_LAST) begin
                        gap_cnt  <= '0;
                        init_idx <= 2'd0;
                        state    <= INIT;
                        wr_valid <= 1'b1;
                        wr_rs    <= 1'b0;
                        wr_data  <= init_cmd(2'd0);
                    end else begin
                        gap_cnt <= gap_cnt + ONE;
                    end
                end
                LOAD: begin
                    snap     <= current_state;
                    state    <= SET_ADDR;
                    wr_valid <= 1'b1;
                    wr_rs    <= 1'b0;
                    wr_data  <= 8'h80;
                end
                IDLE: begin
                    if (current_state != shown_state)
                        state <= LOAD;
                end
                INIT, SET_ADDR, WRITE: begin
                    if (wr_valid) begin
                        // Request held untouched until the core takes it.
                        if (xfer) begin
                            wr_valid <= 1'b0;
                            gap_cnt  <= gap_load;
                        end
                    end else if (gap_cnt > ONE) begin
                        gap_cnt <= gap_cnt - ONE;
                    end else begin
                        // Last gap cycle: the next request appears as the counter hits zero.
                        gap_cnt <= '0;
                        case (state)
                            INIT: begin
                                if (init_idx == 2'd3) begin
                                    init_done <= 1'b1;
                                    state     <= LOAD;
                                end else begin
                                    init_idx <= init_idx + 2'd1;
                                    wr_valid <= 1'b1;
                                    wr_rs    <= 1'b0;
                                    wr_data  <= init_cmd(init_idx + 2'd1);
                                end
                            end
                            SET_ADDR: begin
                                char_idx <= 4'd0;
                                state    <= WRITE;
                                wr_valid <= 1'b1;
                                wr_rs    <= 1'b1;
                                wr_data  <= label_char(snap, 4'd0);
                            end
                            default: begin
                                if (current_state != snap) begin
                                    state <= LOAD;
                                end else if (char_idx == 4'd15) begin
                                    shown_state <= snap;
                                    state       <= IDLE;
                                end else begin
                                    char_idx <= char_idx + 4'd1;
                                    wr_valid <= 1'b1;
                                    wr_rs    <= 1'b1;
                                    wr_data  <= label_char(snap, char_idx + 4'd1);
                                end
                            end
                        endcase
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule
